// File: rtl/eeprom_const_pkg.sv
// Shared constants, state encoding and request check for the SHA-256 constant
// reader.
package eeprom_const_pkg;

    localparam logic [12:0] H_BASE  = 13'd0;
    localparam int          H_WORDS = 8;
    localparam logic [12:0] K_BASE  = 13'd8;
    localparam int          K_WORDS = 64;

    localparam int ACCESS_CYCLES_DEF  = 3;
    localparam int RECOVER_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RECOVER
    } state_e;

    // A request must name at least one word and stay inside its region.
    function automatic logic req_ok(input logic       sel,
                                    input logic [5:0] idx,
                                    input logic [6:0] len);
        logic [7:0] end_idx;
        logic [7:0] words;
        end_idx = {2'b00, idx} + {1'b0, len};
        words   = sel ? 8'(K_WORDS) : 8'(H_WORDS);
        return (len != 7'd0) && (end_idx <= words);
    endfunction

endpackage

// File: rtl/eeprom_wait_counter.sv
// Load/decrement wait-state counter used for both the access and recovery
// phases of an EEPROM read.
module eeprom_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/eeprom_const_reader.sv
// Reads SHA-256 constants from four byte-wide EEPROM lanes and streams the
// assembled 32-bit words to the hash core.
//
// state      | meaning
// IDLE       | strobes high, waiting for START; validates requests
// SETUP      | address presented, strobes still high
// ACCESS     | CE_N/OE_N low for ACCESS_CYCLES; data sampled on the last edge
// RECOVER    | strobes high for RECOVER_CYCLES; VALID in the first cycle
module eeprom_const_reader
    import eeprom_const_pkg::*;
#(
    parameter int ACCESS_CYCLES  = ACCESS_CYCLES_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SEL,
    input  logic [5:0]  IDX,
    input  logic [6:0]  LEN,
    output logic        BUSY,
    output logic [31:0] WORD,
    output logic        VALID,
    output logic        DONE,
    output logic        ERR,
    output logic [12:0] A,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    // Lane bit 0 (its MSB) maps to port bit 7, so D1 lands in WORD[31:24].
    input  logic [7:0]  D1,
    input  logic [7:0]  D2,
    input  logic [7:0]  D3,
    input  logic [7:0]  D4
);

    state_e      state_q, state_d;
    logic [12:0] addr_q, addr_d;
    logic [6:0]  rem_q, rem_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;

    logic        cnt_load;
    logic [3:0]  cnt_load_val;
    logic        cnt_dec;
    logic        cnt_zero;

    eeprom_wait_counter u_wait (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        word_d       = word_q;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = 4'(ACCESS_CYCLES - 1);
        cnt_dec      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (req_ok(SEL, IDX, LEN)) begin
                        addr_d  = (SEL ? K_BASE : H_BASE) + 13'(IDX);
                        rem_d   = LEN;
                        state_d = ST_SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                cnt_load     = 1'b1;
                cnt_load_val = 4'(ACCESS_CYCLES - 1);
                state_d      = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_zero) begin
                    word_d       = {D1, D2, D3, D4};
                    valid_d      = 1'b1;
                    done_d       = (rem_q == 7'd1);
                    cnt_load     = 1'b1;
                    cnt_load_val = 4'(RECOVER_CYCLES - 1);
                    state_d      = ST_RECOVER;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cnt_zero) begin
                    if (rem_q > 7'd1) begin
                        addr_d  = addr_q + 13'd1;
                        rem_d   = rem_q - 7'd1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered from the next state so they change cleanly
        // on the edge that enters or leaves ACCESS.
        ce_n_d = (state_d != ST_ACCESS);
        oe_n_d = (state_d != ST_ACCESS);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= 13'd0;
            rem_q   <= 7'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

    assign BUSY  = busy_q;
    assign WORD  = word_q;
    assign VALID = valid_q;
    assign DONE  = done_q;
    assign ERR   = err_q;
    assign A     = addr_q;
    assign CE_N  = ce_n_q;
    assign OE_N  = oe_n_q;
    assign WE_N  = 1'b1;

endmodule
